// File: rtl/rv32_pkg.sv
// Shared rv32 core definitions: major opcodes, fetch buffer entry and fetch FSM states.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_IMM    = 7'b001_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;
    localparam logic [6:0] OP_LUI    = 7'b011_0111;
    localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OP_REG    = 7'b011_0011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a single-cycle flush.
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same edge, so a full FIFO may still accept a push.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage needs no reset; count/pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// rv32 instruction fetch: owns the PC, issues imem requests, buffers responses and
// presents the head instruction pre-decoded into opcode/func3/func7 for the control unit.
module fetch_stage
    import rv32_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_func3,
    output logic [6:0]      id_func7
);

    fetch_state_e               state;
    fetch_state_e               state_next;
    logic [XLEN-1:0]            pc;
    logic [XLEN-1:0]            rsp_pc;
    logic                       outstanding;
    logic                       outstanding_next;
    logic                       accept;
    logic                       push;
    logic                       pop;
    logic                       space;
    logic                       empty;
    logic [$clog2(FIFO_DEPTH):0] count;
    fetch_entry_t               head;

    // Entries already buffered plus the one in flight must leave room for the next response.
    assign space  = (int'(count) + int'(outstanding) - int'(pop)) < FIFO_DEPTH;
    assign accept = imem_req_valid && imem_req_ready;
    assign push   = (state == RUN) && imem_rsp_valid && !redirect_valid;
    assign pop    = id_valid && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            outstanding <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_next       = state;
        outstanding_next = outstanding;
        imem_req_valid   = 1'b0;
        imem_req_addr    = '0;
        unique case (state)
            IDLE: state_next = RUN;
            RUN: begin
                imem_req_addr  = pc;
                imem_req_valid = space && (!outstanding || imem_rsp_valid);
                if (imem_req_valid && imem_req_ready) outstanding_next = 1'b1;
                else if (imem_rsp_valid)              outstanding_next = 1'b0;
                // Anything still in flight after a redirect is stale and must be swallowed.
                if (redirect_valid && outstanding_next) state_next = DRAIN;
            end
            DRAIN: begin
                imem_req_addr = pc;
                if (imem_rsp_valid) begin
                    outstanding_next = 1'b0;
                    state_next       = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            rsp_pc <= '0;
        end else begin
            if (redirect_valid) pc <= redirect_pc & ~XLEN'(3);
            else if (accept)    pc <= pc + XLEN'(4);
            if (accept) rsp_pc <= pc;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (push),
        .push_data('{pc: rsp_pc, instr: imem_rsp_data}),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .count    (count)
    );

    // Head fields are forced to zero while empty so reset and bubbles present a clean bus.
    assign id_valid  = !empty;
    assign id_pc     = id_valid ? head.pc : '0;
    assign id_instr  = id_valid ? head.instr : '0;
    assign id_opcode = id_instr[6:0];
    assign id_func3  = id_instr[14:12];
    assign id_func7  = id_instr[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a 1-cycle-latency imem responder.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [2:0]  id_func3;
    logic [6:0]  id_func7;

    int checks = 0;
    int errors = 0;

    logic        rsp_auto;
    logic        man_valid;
    logic [31:0] man_data;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_opcode     (id_opcode),
        .id_func3      (id_func3),
        .id_func7      (id_func7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5C3_E0B3;
    endfunction

    // Instruction memory: answers each accepted request one cycle later, or replays a manual value.
    initial begin : imem_model
        logic        fire;
        logic [31:0] faddr;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            fire  = imem_req_valid & imem_req_ready;
            faddr = imem_req_addr;
            @(posedge clk);
            #1;
            if (rsp_auto) begin
                imem_rsp_valid = fire;
                imem_rsp_data  = fire ? instr_of(faddr) : 32'h0;
            end else begin
                imem_rsp_valid = man_valid;
                imem_rsp_data  = man_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic auto_rsp, input logic rdy, input logic idr);
        tick();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = rdy;
        id_ready       = idr;
        @(negedge clk);
        rsp_auto  = auto_rsp;
        man_valid = 1'b0;
        man_data  = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_id(input int budget, output logic found, output logic [31:0] pc,
                           output logic [31:0] ins, output logic [6:0] op,
                           output logic [2:0] f3, output logic [6:0] f7);
        found = 1'b0;
        pc = '0; ins = '0; op = '0; f3 = '0; f7 = '0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (id_valid) begin
                found = 1'b1;
                pc = id_pc; ins = id_instr; op = id_opcode; f3 = id_func3; f7 = id_func7;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset req_addr: got %h expected 0", imem_req_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset id_valid: got %b expected 0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset id_pc: got %h expected 0", id_pc); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset id_instr: got %h expected 0", id_instr); end
    endtask

    task automatic test_stream();
        logic        exp_v;
        logic [31:0] exp_a;
        logic [31:0] exp_pc;
        do_reset(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_v = (k >= 1);
            exp_a = (k >= 1) ? 32'(4 * (k - 1)) : 32'h0;
            checks++; if (imem_req_valid !== exp_v) begin errors++; $display("FAIL stream req_valid k=%0d: got %b expected %b", k, imem_req_valid, exp_v); end
            checks++; if (imem_req_addr !== exp_a) begin errors++; $display("FAIL stream req_addr k=%0d: got %h expected %h", k, imem_req_addr, exp_a); end
            checks++; if (id_valid !== (k >= 3)) begin errors++; $display("FAIL stream id_valid k=%0d: got %b expected %b", k, id_valid, (k >= 3)); end
            if (k >= 3) begin
                exp_pc = 32'(4 * (k - 3));
                checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL stream id_pc k=%0d: got %h expected %h", k, id_pc, exp_pc); end
                checks++; if (id_instr !== instr_of(exp_pc)) begin errors++; $display("FAIL stream id_instr k=%0d: got %h expected %h", k, id_instr, instr_of(exp_pc)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int          n_acc;
        int          n_rsp;
        logic        found;
        logic [31:0] pc, ins;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        n_acc = 0;
        n_rsp = 0;
        do_reset(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (imem_rsp_valid) n_rsp++;
            checks++; if (n_acc - n_rsp > 1 || n_acc - n_rsp < 0) begin errors++; $display("FAIL bp in_flight k=%0d: got %0d expected 0..1", k, n_acc - n_rsp); end
            checks++; if (imem_req_valid !== (k == 1 || k == 2)) begin errors++; $display("FAIL bp req_valid k=%0d: got %b expected %b", k, imem_req_valid, (k == 1 || k == 2)); end
            if (imem_req_valid && imem_req_ready) n_acc++;
            if (k >= 3) begin
                checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++; $display("FAIL bp head k=%0d: got valid=%b pc=%h expected valid=1 pc=0", k, id_valid, id_pc); end
            end
        end
        checks++; if (n_acc !== 2) begin errors++; $display("FAIL bp accepts: got %0d expected 2", n_acc); end
        tick();
        id_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            wait_id(6, found, pc, ins, op, f3, f7);
            checks++; if (!found || pc !== 32'(4 * n) || ins !== instr_of(32'(4 * n))) begin
                errors++; $display("FAIL bp drain n=%0d: got found=%b pc=%h instr=%h expected pc=%h instr=%h", n, found, pc, ins, 32'(4 * n), instr_of(32'(4 * n)));
            end
        end
    endtask

    task automatic test_redirect_outstanding();
        logic        found;
        logic [31:0] pc, ins;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        do_reset(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL redir_out first req: got valid=%b addr=%h expected valid=1 addr=0", imem_req_valid, imem_req_addr); end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_out withdrawn: got %b expected 0", imem_req_valid); end
        man_valid = 1'b1;
        man_data  = instr_of(32'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_out drain req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_out gap id_valid: got %b expected 0", id_valid); end
        man_valid = 1'b0;
        rsp_auto  = 1'b1;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir_out new req: got valid=%b addr=%h expected valid=1 addr=100", imem_req_valid, imem_req_addr); end
        wait_id(5, found, pc, ins, op, f3, f7);
        checks++; if (!found || pc !== 32'h100 || ins !== instr_of(32'h100)) begin errors++; $display("FAIL redir_out first id: got found=%b pc=%h instr=%h expected pc=100 instr=%h", found, pc, ins, instr_of(32'h100)); end
        wait_id(3, found, pc, ins, op, f3, f7);
        checks++; if (!found || pc !== 32'h104) begin errors++; $display("FAIL redir_out second id: got found=%b pc=%h expected pc=104", found, pc); end
    endtask

    task automatic test_redirect_with_rsp();
        logic        found;
        logic [31:0] pc, ins;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        do_reset(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) @(negedge clk);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(negedge clk);
        checks++; if (imem_rsp_valid !== 1'b1 || id_valid !== 1'b1) begin errors++; $display("FAIL redir_rsp setup: got rsp_valid=%b id_valid=%b expected 1 1", imem_rsp_valid, id_valid); end
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        @(negedge clk);
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_rsp flushed: got id_valid=%b expected 0", id_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL redir_rsp next req: got valid=%b addr=%h expected valid=1 addr=200", imem_req_valid, imem_req_addr); end
        wait_id(5, found, pc, ins, op, f3, f7);
        checks++; if (!found || pc !== 32'h200 || ins !== instr_of(32'h200)) begin errors++; $display("FAIL redir_rsp first id: got found=%b pc=%h instr=%h expected pc=200 instr=%h", found, pc, ins, instr_of(32'h200)); end
    endtask

    task automatic test_ready_stall();
        logic        found;
        logic [31:0] pc, ins;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        do_reset(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || id_valid !== 1'b0) begin
                errors++; $display("FAIL stall k=%0d: got valid=%b addr=%h id_valid=%b expected valid=1 addr=0 id_valid=0", k, imem_req_valid, imem_req_addr, id_valid);
            end
        end
        tick();
        imem_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL stall accept addr: got %h expected 0", imem_req_addr); end
        @(negedge clk);
        checks++; if (imem_req_addr !== 32'h4) begin errors++; $display("FAIL stall advance addr: got %h expected 4", imem_req_addr); end
        wait_id(4, found, pc, ins, op, f3, f7);
        checks++; if (!found || pc !== 32'h0) begin errors++; $display("FAIL stall first id: got found=%b pc=%h expected pc=0", found, pc); end
    endtask

    task automatic test_wrap();
        logic        found;
        logic [31:0] pc, ins;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        do_reset(1'b1, 1'b1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap top addr: got valid=%b addr=%h expected valid=1 addr=fffffffc", imem_req_valid, imem_req_addr); end
        @(negedge clk);
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap next addr: got %h expected 0", imem_req_addr); end
        wait_id(4, found, pc, ins, op, f3, f7);
        checks++; if (!found || pc !== 32'hFFFF_FFFC || ins !== 32'h5A3C_1F4F) begin errors++; $display("FAIL wrap id: got found=%b pc=%h instr=%h expected pc=fffffffc instr=5a3c1f4f", found, pc, ins); end
        checks++; if (op !== 7'h4F || f3 !== 3'h1 || f7 !== 7'h2D) begin errors++; $display("FAIL wrap fields: got op=%h f3=%h f7=%h expected op=4f f3=1 f7=2d", op, f3, f7); end
        wait_id(3, found, pc, ins, op, f3, f7);
        checks++; if (!found || pc !== 32'h0) begin errors++; $display("FAIL wrap after: got found=%b pc=%h expected pc=0", found, pc); end
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        rsp_auto       = 1'b1;
        man_valid      = 1'b0;
        man_data       = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_with_rsp();
        test_ready_stall();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
